// File: rtl/l2_pkg.sv
// Shared definitions for the L2 request arbiter slice: bus widths, rw encoding,
// line geometry and the arbiter state type.
package l2_pkg;

  localparam int unsigned L2_REQ_TAG_BITS = 4;
  localparam int unsigned L2_TAG_BITS     = L2_REQ_TAG_BITS + 1;
  localparam int unsigned L2_ADDR_BITS    = 14;
  localparam int unsigned L2_DATA_BITS    = 128;
  localparam int unsigned L2_LINE_BEATS   = 4;

  localparam logic [1:0]  RW_LOAD      = 2'b00;
  localparam int unsigned RW_STORE_BIT = 0;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } l2_state_e;

endpackage

// File: rtl/l2_req_arbiter_if.sv
// Bundle of the two requester ports and the L2 port around l2_req_arbiter.
// slave: arbiter side; master: requesters plus L2 model side.
interface l2_req_arbiter_if #(
  parameter int unsigned REQ_TAG_BITS = 4
);
  import l2_pkg::*;

  logic                    r0_req_val;
  logic                    r0_req_rdy;
  logic [1:0]              r0_req_rw;
  logic [L2_ADDR_BITS-1:0] r0_req_addr;
  logic [L2_DATA_BITS-1:0] r0_req_data;
  logic [REQ_TAG_BITS-1:0] r0_req_tag;
  logic                    r0_resp_val;
  logic [L2_DATA_BITS-1:0] r0_resp_data;
  logic [REQ_TAG_BITS-1:0] r0_resp_tag;

  logic                    r1_req_val;
  logic                    r1_req_rdy;
  logic [1:0]              r1_req_rw;
  logic [L2_ADDR_BITS-1:0] r1_req_addr;
  logic [L2_DATA_BITS-1:0] r1_req_data;
  logic [REQ_TAG_BITS-1:0] r1_req_tag;
  logic                    r1_resp_val;
  logic [L2_DATA_BITS-1:0] r1_resp_data;
  logic [REQ_TAG_BITS-1:0] r1_resp_tag;

  logic                    mem_req_val;
  logic                    mem_req_rdy;
  logic [1:0]              mem_req_rw;
  logic [L2_ADDR_BITS-1:0] mem_req_addr;
  logic [L2_DATA_BITS-1:0] mem_req_data;
  logic [REQ_TAG_BITS:0]   mem_req_tag;
  logic                    mem_resp_val;
  logic [L2_DATA_BITS-1:0] mem_resp_data;
  logic [REQ_TAG_BITS:0]   mem_resp_tag;

  modport slave (
    input  r0_req_val, r0_req_rw, r0_req_addr, r0_req_data, r0_req_tag,
    output r0_req_rdy, r0_resp_val, r0_resp_data, r0_resp_tag,
    input  r1_req_val, r1_req_rw, r1_req_addr, r1_req_data, r1_req_tag,
    output r1_req_rdy, r1_resp_val, r1_resp_data, r1_resp_tag,
    output mem_req_val, mem_req_rw, mem_req_addr, mem_req_data, mem_req_tag,
    input  mem_req_rdy, mem_resp_val, mem_resp_data, mem_resp_tag
  );

  modport master (
    output r0_req_val, r0_req_rw, r0_req_addr, r0_req_data, r0_req_tag,
    input  r0_req_rdy, r0_resp_val, r0_resp_data, r0_resp_tag,
    output r1_req_val, r1_req_rw, r1_req_addr, r1_req_data, r1_req_tag,
    input  r1_req_rdy, r1_resp_val, r1_resp_data, r1_resp_tag,
    input  mem_req_val, mem_req_rw, mem_req_addr, mem_req_data, mem_req_tag,
    output mem_req_rdy, mem_resp_val, mem_resp_data, mem_resp_tag
  );

endinterface

// File: rtl/l2_rr_pick.sv
// Two-way round-robin picker: a lone valid wins outright, a tie goes to ptr_i.
module l2_rr_pick (
  input  logic [1:0] valid_i,
  input  logic       ptr_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = '0;
    if (valid_i == 2'b11) grant_o[ptr_i] = 1'b1;
    else                  grant_o = valid_i;
  end

endmodule

// File: rtl/l2_req_arbiter.sv
// Two-requester front end onto one L2 port: zero-latency round-robin request mux
// and registered response demux. L2ARB_WB_LOCK_EN adds a 4-beat store burst lock.
module l2_req_arbiter
  import l2_pkg::*;
#(
  parameter int unsigned REQ_TAG_BITS = 4
) (
  input logic              clk,
  input logic              reset,
  l2_req_arbiter_if.slave  bus
);

  logic [1:0]              req_val;
  logic [1:0]              req_store;
  logic [1:0]              elig;
  logic [1:0]              grant;
  logic                    sel;
  logic                    hs;
  logic                    ptr_q, ptr_d;
  logic                    in_lock;
  logic                    owner;
  logic                    lock_exit;
  logic [1:0]              resp_val_q, resp_val_d;
  logic [L2_DATA_BITS-1:0] resp_data_q, resp_data_d;
  logic [REQ_TAG_BITS-1:0] resp_tag_q, resp_tag_d;

  assign req_val   = {bus.r1_req_val, bus.r0_req_val};
  assign req_store = {bus.r1_req_rw[RW_STORE_BIT], bus.r0_req_rw[RW_STORE_BIT]};

  // While locked only the owner's stores compete; its loads wait for the burst end.
  always_comb begin
    elig = '0;
    for (int unsigned n = 0; n < 2; n++) begin
      elig[n] = req_val[n] & (~in_lock | ((owner == n[0]) & req_store[n]));
    end
  end

  l2_rr_pick u_pick (
    .valid_i (elig),
    .ptr_i   (ptr_q),
    .grant_o (grant)
  );

  assign sel = grant[1];
  assign hs  = bus.mem_req_val & bus.mem_req_rdy;

  assign bus.mem_req_val  = (|elig) & ~reset;
  assign bus.r0_req_rdy   = bus.mem_req_rdy & grant[0] & ~reset;
  assign bus.r1_req_rdy   = bus.mem_req_rdy & grant[1] & ~reset;
  assign bus.mem_req_rw   = sel ? bus.r1_req_rw   : bus.r0_req_rw;
  assign bus.mem_req_addr = sel ? bus.r1_req_addr : bus.r0_req_addr;
  assign bus.mem_req_data = sel ? bus.r1_req_data : bus.r0_req_data;
  assign bus.mem_req_tag  = {sel, (sel ? bus.r1_req_tag : bus.r0_req_tag)};

`ifdef L2ARB_WB_LOCK_EN
  l2_state_e  state_q, state_d;
  logic       owner_q, owner_d;
  logic [1:0] beat_q, beat_d;

  assign in_lock   = (state_q == LOCK);
  assign owner     = owner_q;
  assign lock_exit = in_lock & hs & (beat_q == 2'(L2_LINE_BEATS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB;
      owner_q <= 1'b0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      beat_q  <= beat_d;
    end
  end

  // The store that opens the burst is beat 0, so the counter leaves ARB at 1.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    beat_d  = beat_q;
    case (state_q)
      ARB: begin
        if (hs && req_store[sel]) begin
          state_d = LOCK;
          owner_d = sel;
          beat_d  = 2'd1;
        end
      end
      LOCK: begin
        if (hs) begin
          beat_d = beat_q + 2'd1;
          if (lock_exit) state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end
`else
  assign in_lock   = 1'b0;
  assign owner     = 1'b0;
  assign lock_exit = 1'b0;
`endif

  always_comb begin
    ptr_d = ptr_q;
    if (hs) begin
      if (!in_lock)       ptr_d = ~sel;
      else if (lock_exit) ptr_d = ~owner;
    end
  end

  always_comb begin
    resp_val_d  = '0;
    resp_data_d = resp_data_q;
    resp_tag_d  = resp_tag_q;
    if (bus.mem_resp_val) begin
      resp_val_d[bus.mem_resp_tag[REQ_TAG_BITS]] = 1'b1;
      resp_data_d = bus.mem_resp_data;
      resp_tag_d  = bus.mem_resp_tag[REQ_TAG_BITS-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= 1'b0;
      resp_val_q  <= '0;
      resp_data_q <= '0;
      resp_tag_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      resp_val_q  <= resp_val_d;
      resp_data_q <= resp_data_d;
      resp_tag_q  <= resp_tag_d;
    end
  end

  assign bus.r0_resp_val  = resp_val_q[0];
  assign bus.r1_resp_val  = resp_val_q[1];
  assign bus.r0_resp_data = resp_data_q;
  assign bus.r1_resp_data = resp_data_q;
  assign bus.r0_resp_tag  = resp_tag_q;
  assign bus.r1_resp_tag  = resp_tag_q;

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Directed bench for l2_req_arbiter with a per-cycle reference model of the
// arbitration and response rules; expectations follow L2ARB_WB_LOCK_EN.
module tb_l2_req_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  l2_req_arbiter_if #(.REQ_TAG_BITS(4)) bus ();

  l2_req_arbiter #(.REQ_TAG_BITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.r0_req_val   = 1'b0;
    bus.r0_req_rw    = 2'b00;
    bus.r0_req_addr  = '0;
    bus.r0_req_data  = '0;
    bus.r0_req_tag   = '0;
    bus.r1_req_val   = 1'b0;
    bus.r1_req_rw    = 2'b00;
    bus.r1_req_addr  = '0;
    bus.r1_req_data  = '0;
    bus.r1_req_tag   = '0;
    bus.mem_resp_val = 1'b0;
    bus.mem_resp_data = '0;
    bus.mem_resp_tag = '0;
  endtask

  // Reference model: pointer, remaining locked store beats, owner, pending response.
  int           m_ptr = 0;
  int           m_left = 0;
  int           m_owner = 0;
  bit           m_rv0 = 0;
  bit           m_rv1 = 0;
  logic [127:0] m_rdata = '0;
  logic [3:0]   m_rtag = '0;

  initial begin : model
    bit           v[2];
    bit           st[2];
    bit           e[2];
    int           win;
    bit           ev, hs, st_win, rst_s, pv;
    logic [4:0]   pt;
    logic [127:0] pd;
    forever begin
      @(negedge clk);
      v[0] = bus.r0_req_val;  v[1] = bus.r1_req_val;
      st[0] = bus.r0_req_rw[0]; st[1] = bus.r1_req_rw[0];
      for (int n = 0; n < 2; n++) e[n] = v[n] && (m_left == 0 || (n == m_owner && st[n]));
      if (e[0] && e[1]) win = m_ptr;
      else if (e[0])    win = 0;
      else if (e[1])    win = 1;
      else              win = -1;
      ev = !reset && (win >= 0);
      chk("mem_req_val", 128'(bus.mem_req_val), 128'(ev));
      chk("r0_req_rdy", 128'(bus.r0_req_rdy), 128'(ev && bus.mem_req_rdy && win == 0));
      chk("r1_req_rdy", 128'(bus.r1_req_rdy), 128'(ev && bus.mem_req_rdy && win == 1));
      if (ev) begin
        if (win == 0) begin
          chk("mem_req_tag", 128'(bus.mem_req_tag), 128'({1'b0, bus.r0_req_tag}));
          chk("mem_req_addr", 128'(bus.mem_req_addr), 128'(bus.r0_req_addr));
          chk("mem_req_data", bus.mem_req_data, bus.r0_req_data);
          chk("mem_req_rw", 128'(bus.mem_req_rw), 128'(bus.r0_req_rw));
        end else begin
          chk("mem_req_tag", 128'(bus.mem_req_tag), 128'({1'b1, bus.r1_req_tag}));
          chk("mem_req_addr", 128'(bus.mem_req_addr), 128'(bus.r1_req_addr));
          chk("mem_req_data", bus.mem_req_data, bus.r1_req_data);
          chk("mem_req_rw", 128'(bus.mem_req_rw), 128'(bus.r1_req_rw));
        end
      end
      chk("r0_resp_val", 128'(bus.r0_resp_val), 128'(m_rv0));
      chk("r1_resp_val", 128'(bus.r1_resp_val), 128'(m_rv1));
      if (m_rv0 || m_rv1) begin
        chk("r0_resp_data", bus.r0_resp_data, m_rdata);
        chk("r1_resp_data", bus.r1_resp_data, m_rdata);
        chk("r0_resp_tag", 128'(bus.r0_resp_tag), 128'(m_rtag));
        chk("r1_resp_tag", 128'(bus.r1_resp_tag), 128'(m_rtag));
      end
      hs     = ev && bus.mem_req_rdy;
      st_win = (win >= 0) ? st[win] : 1'b0;
      rst_s  = reset;
      pv = bus.mem_resp_val; pt = bus.mem_resp_tag; pd = bus.mem_resp_data;
      @(posedge clk);
      if (rst_s) begin
        m_ptr = 0; m_left = 0; m_owner = 0;
        m_rv0 = 0; m_rv1 = 0; m_rdata = '0; m_rtag = '0;
      end else begin
        if (hs) begin
          if (m_left == 0) begin
            m_ptr = 1 - win;
`ifdef L2ARB_WB_LOCK_EN
            if (st_win) begin
              m_left  = 3;
              m_owner = win;
            end
`endif
          end else begin
            m_left = m_left - 1;
            if (m_left == 0) m_ptr = 1 - m_owner;
          end
        end
        m_rv0 = pv && !pt[4];
        m_rv1 = pv &&  pt[4];
        if (pv) begin
          m_rdata = pd;
          m_rtag  = pt[3:0];
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int gseq[8];
    int exp_seq[5];
    int g_n;
    int i;
    bit adv0, adv1;

    reset = 1'b1;
    idle();
    bus.mem_req_rdy = 1'b0;
    repeat (2) step();

    // Request during reset must not be offered or accepted.
    bus.r0_req_val  = 1'b1;
    bus.mem_req_rdy = 1'b1;
    @(negedge clk);
    chk("rst_mem_req_val", 128'(bus.mem_req_val), 128'(1'b0));
    chk("rst_r0_rdy", 128'(bus.r0_req_rdy), 128'(1'b0));
    step();
    reset = 1'b0;
    idle();
    @(negedge clk);
    chk("rst_r0_resp_val", 128'(bus.r0_resp_val), 128'(1'b0));
    chk("rst_r1_resp_val", 128'(bus.r1_resp_val), 128'(1'b0));
    chk("rst_resp_data", bus.r0_resp_data, 128'h0);
    chk("rst_resp_tag", 128'(bus.r1_resp_tag), 128'h0);

    // A: simultaneous loads, r0 first then r1
    step();
    bus.r0_req_val = 1'b1; bus.r0_req_rw = 2'b00; bus.r0_req_addr = 14'h010; bus.r0_req_tag = 4'h5;
    bus.r1_req_val = 1'b1; bus.r1_req_rw = 2'b00; bus.r1_req_addr = 14'h020; bus.r1_req_tag = 4'h3;
    @(negedge clk);
    chk("A_c0_r0_rdy", 128'(bus.r0_req_rdy), 128'(1'b1));
    chk("A_c0_r1_rdy", 128'(bus.r1_req_rdy), 128'(1'b0));
    chk("A_c0_tag", 128'(bus.mem_req_tag), 128'(5'h05));
    chk("A_c0_addr", 128'(bus.mem_req_addr), 128'(14'h010));
    step();
    bus.r0_req_val = 1'b0;
    @(negedge clk);
    chk("A_c1_r1_rdy", 128'(bus.r1_req_rdy), 128'(1'b1));
    chk("A_c1_tag", 128'(bus.mem_req_tag), 128'(5'h13));
    chk("A_c1_addr", 128'(bus.mem_req_addr), 128'(14'h020));
    step();
    bus.r1_req_val = 1'b0;

    // B: 4-beat load response to r1, then one beat to r0
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) step();
      if (k < 4) begin
        bus.mem_resp_val  = 1'b1;
        bus.mem_resp_tag  = 5'b1_0011;
        bus.mem_resp_data = {4{32'hA5A5_0000 + 32'(k)}};
      end else begin
        bus.mem_resp_val = 1'b0;
      end
      @(negedge clk);
      if (k > 0) begin
        chk("B_r1_resp_val", 128'(bus.r1_resp_val), 128'(1'b1));
        chk("B_r0_resp_val", 128'(bus.r0_resp_val), 128'(1'b0));
        chk("B_resp_tag", 128'(bus.r1_resp_tag), 128'(4'b0011));
        chk("B_resp_data", bus.r1_resp_data, {4{32'hA5A5_0000 + 32'(k - 1)}});
      end
    end
    step();
    bus.mem_resp_val = 1'b1; bus.mem_resp_tag = 5'h0A; bus.mem_resp_data = 128'h1234;
    @(negedge clk);
    chk("B_r1_resp_end", 128'(bus.r1_resp_val), 128'(1'b0));
    step();
    bus.mem_resp_val = 1'b0;
    @(negedge clk);
    chk("B_r0_resp_val", 128'(bus.r0_resp_val), 128'(1'b1));
    chk("B_r0_resp_tag", 128'(bus.r0_resp_tag), 128'(4'hA));

    // C: r0 alone moves pointer to r1, then a 3-cycle stall with both valid
    step();
    bus.r0_req_val = 1'b1; bus.r0_req_addr = 14'h030; bus.r0_req_tag = 4'h6;
    @(negedge clk);
    chk("C_pre_r0_rdy", 128'(bus.r0_req_rdy), 128'(1'b1));
    step();
    bus.r1_req_val = 1'b1; bus.r1_req_addr = 14'h040; bus.r1_req_tag = 4'h9;
    bus.mem_req_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("C_stall_r0_rdy", 128'(bus.r0_req_rdy), 128'(1'b0));
      chk("C_stall_r1_rdy", 128'(bus.r1_req_rdy), 128'(1'b0));
      step();
    end
    bus.mem_req_rdy = 1'b1;
    @(negedge clk);
    chk("C_rel_r1_rdy", 128'(bus.r1_req_rdy), 128'(1'b1));
    chk("C_rel_r0_rdy", 128'(bus.r0_req_rdy), 128'(1'b0));
    step();
    idle();

    // D: r0 four-store line while r1 holds a load
`ifdef L2ARB_WB_LOCK_EN
    exp_seq = '{0, 0, 0, 0, 1};
`else
    exp_seq = '{0, 1, 0, 0, 0};
`endif
    for (int k = 0; k < 8; k++) gseq[k] = 9;
    g_n = 0;
    i = 0;
    step();
    bus.r0_req_val = 1'b1; bus.r0_req_rw = 2'b01; bus.r0_req_tag = 4'h1;
    bus.r0_req_addr = 14'h100; bus.r0_req_data = 128'hD0;
    bus.r1_req_val = 1'b1; bus.r1_req_rw = 2'b00; bus.r1_req_tag = 4'h7;
    bus.r1_req_addr = 14'h200;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      adv0 = bus.r0_req_rdy;
      adv1 = bus.r1_req_rdy;
      if (adv0) begin
        if (g_n < 8) gseq[g_n] = 0;
        g_n++;
      end
      if (adv1) begin
        if (g_n < 8) gseq[g_n] = 1;
        g_n++;
      end
      step();
      if (adv0) begin
        i++;
        if (i == 4) bus.r0_req_val = 1'b0;
        else begin
          bus.r0_req_addr = 14'h100 + 14'(i);
          bus.r0_req_data = 128'hD0 + 128'(i);
        end
      end
      if (adv1) bus.r1_req_val = 1'b0;
    end
    chk("D_grant_count", 128'(g_n), 128'(5));
    for (int k = 0; k < 5; k++) chk($sformatf("D_grant%0d", k), 128'(gseq[k]), 128'(exp_seq[k]));
    idle();

    // E: reset two beats into a store burst, with a response in flight
    step();
    bus.r0_req_val = 1'b1; bus.r0_req_rw = 2'b01; bus.r0_req_addr = 14'h180; bus.r0_req_tag = 4'h2;
    bus.r1_req_val = 1'b1; bus.r1_req_rw = 2'b00; bus.r1_req_addr = 14'h280; bus.r1_req_tag = 4'hB;
    step();
    bus.r0_req_addr = 14'h181;
`ifdef L2ARB_WB_LOCK_EN
    @(negedge clk);
    chk("E_locked_r1_rdy", 128'(bus.r1_req_rdy), 128'(1'b0));
`endif
    step();
    reset = 1'b1;
    bus.mem_resp_val = 1'b1; bus.mem_resp_tag = 5'h1C; bus.mem_resp_data = 128'hBEEF;
    @(negedge clk);
    chk("E_rst_r0_rdy", 128'(bus.r0_req_rdy), 128'(1'b0));
    step();
    reset = 1'b0;
    bus.mem_resp_val = 1'b0;
    bus.r0_req_rw = 2'b00;
    @(negedge clk);
    chk("E_post_r0_rdy", 128'(bus.r0_req_rdy), 128'(1'b1));
    chk("E_post_r1_rdy", 128'(bus.r1_req_rdy), 128'(1'b0));
    chk("E_post_tag_msb", 128'(bus.mem_req_tag[4]), 128'(1'b0));
    chk("E_post_r1_resp", 128'(bus.r1_resp_val), 128'(1'b0));
    step();
    idle();
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l2_req_arbiter.md
L2_REQ_ARBITER -- requirements
Module: l2_req_arbiter

Interface
REQ-001 Parameter: REQ_TAG_BITS, default 4, requester tag width; the L2-side tag is REQ_TAG_BITS+1 bits (5 at default).
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 rN_req_val  input  1  requester N (N=0,1) request valid.
REQ-005 rN_req_rdy  output  1  requester N request accepted this cycle.
REQ-006 rN_req_rw  input  2  request type: 2'b00 is a 4-beat line load; rw[0]=1 is a single-beat store.
REQ-007 rN_req_addr  input  14  128-bit word address.
REQ-008 rN_req_data  input  128  store data.
REQ-009 rN_req_tag  input  REQ_TAG_BITS  requester transaction tag.
REQ-010 rN_resp_val  output  1  response beat valid for requester N.
REQ-011 rN_resp_data  output  128  response data, shared by both requesters.
REQ-012 rN_resp_tag  output  REQ_TAG_BITS  response tag, shared by both requesters.
REQ-013 mem_req_val / mem_req_rdy / mem_req_rw / mem_req_addr / mem_req_data / mem_req_tag  out/in/out/out/out/out  1/1/2/14/128/REQ_TAG_BITS+1  L2 request port.
REQ-014 mem_resp_val / mem_resp_data / mem_resp_tag  input  1/128/REQ_TAG_BITS+1  L2 response port; no backpressure.

Function
REQ-015 Arbitration is combinational from rN_req_val, mem_req_rdy, the priority pointer and the FSM state; the selected request is muxed onto mem_req_* with zero cycles of latency.
REQ-016 mem_req_val = 1 whenever any eligible requester is valid; rN_req_rdy = mem_req_rdy & grant[N]; at most one grant per cycle.
REQ-017 mem_req_tag = {N, rN_req_tag}; the MSB identifies the requester.
REQ-018 Priority is round-robin: the pointer toggles to the other requester after each accepted handshake (mem_req_val & mem_req_rdy); the pointer resets to requester 0.
REQ-019 When only one requester is valid, it is granted regardless of the pointer.
REQ-020 Responses are registered with 1 cycle latency: rN_resp_val = reg(mem_resp_val & (mem_resp_tag MSB == N)); data and the low tag bits are registered alongside.
REQ-021 Back-to-back responses, including all 4 beats of a load, pass at 1 beat/cycle without loss.
REQ-022 States: ARB (free arbitration) and LOCK (owned by one requester).
REQ-023 ARB -> LOCK on an accepted store when L2ARB_WB_LOCK_EN is defined.
REQ-024 LOCK: only the lock owner is eligible, and the other requester's rdy = 0.
REQ-025 A 2-bit beat counter counts accepted owner stores; LOCK -> ARB after the 4th store beat of the line (counter wraps 3->0).
REQ-026 In LOCK, an owner load request is not granted until the burst completes.
REQ-027 The pointer does not toggle during LOCK; on exit it points to the non-owner.
REQ-028 mem_req_rdy low stalls everything: no pointer, counter or state change.

Reset
REQ-029 Reset applies to: state=ARB, pointer=0, beat counter=0, all rN_resp_val=0, response data/tag registers=0.
REQ-030 Combinational outputs follow inputs during reset, but rN_req_rdy = 0 and mem_req_val = 0 while reset is high.
REQ-031 Reset mid-burst abandons the lock; no response from before reset is delivered after reset.

Configuration
REQ-032 Macro L2ARB_WB_LOCK_EN, when defined, enables the LOCK state and the 4-beat store burst lock.
REQ-033 When L2ARB_WB_LOCK_EN is undefined, the FSM remains in ARB permanently, every store is arbitrated independently, and the counter logic is absent.

Structure
REQ-034 Shared package l2_pkg holds: L2_TAG_BITS, L2_ADDR_BITS=14, L2_DATA_BITS=128, rw encodings (RW_LOAD=2'b00, store bit 0), L2_LINE_BEATS=4, and state enum {ARB, LOCK}.
REQ-035 Sub-module l2_rr_pick: a 2-way round-robin picker (valid[1:0], ptr -> grant[1:0]); all other logic is in the top module.

Verification
REQ-036 Both requesters issue simultaneous loads after reset, with mem_req_rdy=1 -> r0 is granted in cycle 0 with mem_req_tag=5'b0_xxxx, r1 is granted in cycle 1 with tag 5'b1_xxxx.
REQ-037 L2 returns 4 beats with tag 5'b1_0011 -> r1_resp_val is high for 4 consecutive cycles starting 1 cycle later, resp_tag=4'b0011, and r0_resp_val stays 0.
REQ-038 With LOCK_EN defined, r0 sends 4 stores to addr 0x100-0x103 while r1 holds a load valid -> r1_rdy=0 for 4 accepted beats, then r1 is granted on the next cycle.
REQ-039 With LOCK_EN undefined and the same stimulus -> grants alternate r0, r1, r0, r0, r0.
REQ-040 mem_req_rdy is held 0 for 3 cycles with both requesters valid -> no rdy is asserted and the pointer is unchanged; after release, the grant goes to the pointer's requester.
REQ-041 Reset is asserted after the 2nd store beat of a locked burst -> state=ARB, and the next grant goes to r0 when both requesters are valid.
